// File: rtl/noc_packetizer.sv
// Local-port NoC injector: frames AXI-Stream bursts into header + payload packets, splitting long bursts.
// Optional macro NOC_PACKETIZER_SRC_EN writes ROUTER_X/ROUTER_Y into the header source fields.
module noc_packetizer #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int MAX_PACKAGES  = 4,
  parameter int ROUTER_X      = 0,
  parameter int ROUTER_Y      = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_last,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [$clog2(MAX_ROUTERS_X)-1:0]  dest_x,
  input  logic [$clog2(MAX_ROUTERS_Y)-1:0]  dest_y,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic                              out_valid,
  input  logic                              out_ready
);
  localparam int X_W = $clog2(MAX_ROUTERS_X);
  localparam int Y_W = $clog2(MAX_ROUTERS_Y);
  localparam int C_W = $clog2(MAX_PACKAGES);
  localparam logic [C_W:0] MAX_CNT = (C_W+1)'(MAX_PACKAGES);
  localparam logic [C_W:0] ONE_CNT = (C_W+1)'(1);

`ifdef NOC_PACKETIZER_SRC_EN
  localparam logic [X_W-1:0] SRC_X = X_W'(ROUTER_X);
  localparam logic [Y_W-1:0] SRC_Y = Y_W'(ROUTER_Y);
`else
  // Source fields forced to zero; parameters stay referenced so both builds share one port list.
  localparam logic [X_W-1:0] SRC_X = X_W'(ROUTER_X * 0);
  localparam logic [Y_W-1:0] SRC_Y = Y_W'(ROUTER_Y * 0);
`endif

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HEADER  = 2'd1,
    BODY    = 2'd2
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] pbuf_r [MAX_PACKAGES];
  logic [C_W:0]          wr_r;
  logic [C_W:0]          rd_r;
  logic                  mid_burst_r;
  logic [X_W-1:0]        dest_x_r;
  logic [Y_W-1:0]        dest_y_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_last_r;
  logic                  out_valid_r;

  logic                  accept_s;
  logic [C_W:0]          wr_next_s;
  logic [C_W:0]          rd_next_s;
  logic [X_W-1:0]        hdr_dx_s;
  logic [Y_W-1:0]        hdr_dy_s;

  function automatic logic [DATA_WIDTH-1:0] build_header(
    input logic [X_W-1:0] dx,
    input logic [Y_W-1:0] dy,
    input logic [C_W-1:0] cnt,
    input logic           tail
  );
    logic [DATA_WIDTH-1:0] h;
    h                             = '0;
    h[X_W-1:0]                    = dx;
    h[X_W +: Y_W]                 = dy;
    h[X_W+Y_W +: C_W]             = cnt;
    h[X_W+Y_W+C_W +: X_W]         = SRC_X;
    h[2*X_W+Y_W+C_W +: Y_W]       = SRC_Y;
    h[DATA_WIDTH-1]               = tail;
    return h;
  endfunction

  assign in_ready  = (state_r == COLLECT);
  assign accept_s  = in_valid && in_ready;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_valid = out_valid_r;

  // Header destination: live inputs on the first beat of a burst, latched copy for continuations.
  always_comb begin
    wr_next_s = wr_r + ONE_CNT;
    rd_next_s = rd_r + ONE_CNT;
    if (mid_burst_r) begin
      hdr_dx_s = dest_x_r;
      hdr_dy_s = dest_y_r;
    end else begin
      hdr_dx_s = dest_x;
      hdr_dy_s = dest_y;
    end
  end

  // Collect / header / body sequencer with registered flit outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= COLLECT;
      wr_r        <= '0;
      rd_r        <= '0;
      mid_burst_r <= 1'b0;
      dest_x_r    <= '0;
      dest_y_r    <= '0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      for (int i = 0; i < MAX_PACKAGES; i++) begin
        pbuf_r[i] <= '0;
      end
    end else begin
      case (state_r)
        COLLECT: begin
          if (accept_s) begin
            pbuf_r[wr_r[C_W-1:0]] <= in_data;
            wr_r                  <= wr_next_s;
            if (!mid_burst_r) begin
              dest_x_r <= dest_x;
              dest_y_r <= dest_y;
            end
            if (in_last || (wr_next_s == MAX_CNT)) begin
              state_r     <= HEADER;
              out_valid_r <= 1'b1;
              out_last_r  <= 1'b0;
              out_data_r  <= build_header(hdr_dx_s, hdr_dy_s, wr_r[C_W-1:0], in_last);
              mid_burst_r <= !in_last;
            end else begin
              mid_burst_r <= 1'b1;
            end
          end
        end
        HEADER: begin
          if (out_ready) begin
            state_r    <= BODY;
            rd_r       <= '0;
            out_data_r <= pbuf_r[0];
            out_last_r <= (wr_r == ONE_CNT);
          end
        end
        BODY: begin
          if (out_ready) begin
            if (out_last_r) begin
              state_r     <= COLLECT;
              wr_r        <= '0;
              rd_r        <= '0;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              out_data_r  <= '0;
            end else begin
              rd_r       <= rd_next_s;
              out_data_r <= pbuf_r[rd_next_s[C_W-1:0]];
              out_last_r <= (rd_next_s == (wr_r - ONE_CNT));
            end
          end
        end
        default: begin
          state_r     <= COLLECT;
          wr_r        <= '0;
          rd_r        <= '0;
          mid_burst_r <= 1'b0;
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          out_data_r  <= '0;
        end
      endcase
    end
  end

endmodule
